arb_frame_parser: RTL and testbench
===================================

# arb_frame_parser

Parametrised frame parser and spread evaluator for the arbitrage engine. It consumes received UART bytes carrying frames of the form header, N_EXCH big-endian prices, XOR checksum, footer. It validates each frame and publishes the prices. It also computes the lowest price (buy), the highest price (sell) and the spread, and flags whether the spread exceeds a threshold. It sits between the UART receiver and the trade/report logic. It generalises the fixed two-exchange, 16-bit, unchecked frame format to N exchanges of configurable width, and adds checksum validation and an inter-byte timeout.

## Interface
- N_EXCH, 2, number of exchange prices per frame (2..32)
- PRICE_BYTES, 2, bytes per price; PW = 8*PRICE_BYTES
- HEADER, 8'hAA, frame start byte
- FOOTER, 8'h55, frame end byte
- TIMEOUT_CYCLES, 50000, maximum clock cycles between consecutive bytes inside a frame (1 ms at 50 MHz)
- MIN_SPREAD, 0, profit threshold in price units (PW bits)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe qualifying rx_data
- prices  out  N_EXCH*PW  published prices; exchange k at bits [k*PW +: PW]
- buy_idx  out  IW  index of the minimum price; IW = max(1, clog2(N_EXCH))
- sell_idx  out  IW  index of the maximum price
- spread  out  PW  max price minus min price (unsigned)
- profitable  out  1  spread > MIN_SPREAD
- out_valid  out  1  one-cycle pulse when a good frame's results are published
- frame_err  out  1  one-cycle pulse when a frame is rejected
- err_code  out  2  1 = checksum, 2 = footer, 3 = timeout; held until the next error

## Operation
- All outputs are registered. On reset, every output is 0 and the FSM is in IDLE.
- IDLE: bytes that are not HEADER are ignored. A HEADER byte moves the FSM to PRICE, clears the byte counter and checksum accumulator, and clears the timeout counter.
- PRICE: collects N_EXCH*PRICE_BYTES bytes, MSB-first within each price and exchange 0 first, into shadow registers. Each byte is XORed into the checksum accumulator. A byte equal to HEADER or FOOTER here is data; there is no resync. After the last byte the FSM moves to CHECK.
- CHECK: the next byte must equal the accumulated XOR. Match moves to FOOT. Mismatch gives error 1 and a return to IDLE.
- FOOT: the next byte must equal FOOTER. Match moves to SCAN. Mismatch gives error 2 and a return to IDLE.
- SCAN: one shadow price is compared per cycle for k = 0..N_EXCH-1.
  - The minimum uses strict <, so the lowest index wins ties.
  - The maximum uses strict >, so the lowest index wins ties.
- DONE: copies shadow prices to prices, and updates buy_idx, sell_idx, spread and profitable. Pulses out_valid, then returns to IDLE.
- Timeout: in PRICE, CHECK or FOOT, a counter increments every cycle without rx_valid and resets on each accepted byte. Reaching TIMEOUT_CYCLES gives error 3 and a return to IDLE.
- Error handling: frame_err pulses for one cycle and err_code is updated. prices and the result outputs keep the last good frame.
- rx_valid during SCAN or DONE: the byte is dropped. UART byte spacing (≥ 5200 cycles) guarantees this does not occur in service.
- If all prices are equal: buy_idx = sell_idx = 0, spread = 0, profitable = 0.

## Timing
- frame_err asserts in the cycle after the rx_valid of the offending byte. For a timeout it asserts in the cycle after the counter reaches TIMEOUT_CYCLES.
- out_valid asserts exactly N_EXCH+1 cycles after the cycle in which the footer byte's rx_valid is high. The result outputs change in that same cycle.
- out_valid and frame_err are never high together.
- Assertion of rst mid-frame immediately clears all state and outputs. The first byte accepted after release is treated as in IDLE.

## Test plan
- N_EXCH=2, PB=2: bytes AA 10 AE 10 8B 25 55 → out_valid 3 cycles after the footer; prices = {4235, 4270}; buy_idx 1, sell_idx 0, spread 35, profitable 1.
- Same frame with checksum byte 24 → frame_err with err_code 1; out_valid stays 0; prices unchanged from the previous good frame.
- Bytes 00 55 13 ahead of a valid frame, and footer replaced by 56 → leading bytes ignored; footer error gives err_code 2. A following good frame is then parsed correctly.
- N_EXCH=4: AA 00 64 01 2C 00 32 01 2C 56 55 (prices 100, 300, 50, 300) → buy_idx 2, sell_idx 1, spread 250, out_valid 5 cycles after the footer.
- AA 10 AE, then silence → frame_err with err_code 3 in the cycle after the counter hits TIMEOUT_CYCLES; the next header starts a fresh frame.
- rst pulled low after 4 bytes of a frame → all outputs 0 immediately. A complete good frame after release produces correct results; the partial frame produces none.

Source files
------------

// File: rtl/arb_frame_parser.sv
// rtl/arb_frame_parser.sv - validating frame parser and min/max spread evaluator for N exchange prices
//
// Frame format: HEADER, N_EXCH big-endian prices of PRICE_BYTES each, XOR checksum, FOOTER.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   rx_data, rx_valid received byte and its one-cycle qualifier
//   prices            last good frame's prices, exchange k at [k*PW +: PW]
//   buy_idx, sell_idx index of the minimum / maximum price (lowest index wins ties)
//   spread            max price minus min price
//   profitable        spread > MIN_SPREAD
//   out_valid         one-cycle pulse when results are published
//   frame_err         one-cycle pulse when a frame is rejected
//   err_code          1 checksum, 2 footer, 3 timeout; held until the next error

module arb_frame_parser #(
   parameter int                       N_EXCH         = 2,
   parameter int                       PRICE_BYTES    = 2,
   parameter logic [7:0]               HEADER         = 8'hAA,
   parameter logic [7:0]               FOOTER         = 8'h55,
   parameter int                       TIMEOUT_CYCLES = 50000,
   parameter logic [8*PRICE_BYTES-1:0] MIN_SPREAD     = '0,
   localparam int                      PW             = 8 * PRICE_BYTES,
   localparam int                      IW             = (N_EXCH > 2) ? $clog2(N_EXCH) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             rx_data,
   input  logic                   rx_valid,
   output logic [N_EXCH*PW-1:0]   prices,
   output logic [IW-1:0]          buy_idx,
   output logic [IW-1:0]          sell_idx,
   output logic [PW-1:0]          spread,
   output logic                   profitable,
   output logic                   out_valid,
   output logic                   frame_err,
   output logic [1:0]             err_code
);

   localparam int BW = (PRICE_BYTES > 1) ? $clog2(PRICE_BYTES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRICE,
      S_CHECK,
      S_FOOT,
      S_SCAN,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          pidx_q, pidx_d;        // exchange being received
   logic [BW-1:0]          bidx_q, bidx_d;        // byte within the current price
   logic [7:0]             csum_q, csum_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [N_EXCH*PW-1:0]   shadow_q, shadow_d;
   logic [IW-1:0]          scan_q, scan_d;
   logic [PW-1:0]          min_q, min_d;
   logic [PW-1:0]          max_q, max_d;
   logic [IW-1:0]          min_idx_q, min_idx_d;
   logic [IW-1:0]          max_idx_q, max_idx_d;

   logic [N_EXCH*PW-1:0]   prices_q, prices_d;
   logic [IW-1:0]          buy_idx_q, buy_idx_d;
   logic [IW-1:0]          sell_idx_q, sell_idx_d;
   logic [PW-1:0]          spread_q, spread_d;
   logic                   profitable_q, profitable_d;
   logic                   out_valid_q, out_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic [1:0]             err_code_q, err_code_d;

   logic                   in_frame;
   logic [PW-1:0]          cur_price;
   logic [PW-1:0]          min_n, max_n, spread_n;
   logic [IW-1:0]          min_idx_n, max_idx_n;

   assign in_frame = (state_q == S_PRICE) || (state_q == S_CHECK) || (state_q == S_FOOT);

   // Shadow price currently under comparison during SCAN.
   always_comb begin
      cur_price = '0;
      for (int k = 0; k < N_EXCH; k++) begin
         if (scan_q == IW'(k)) begin
            cur_price = shadow_q[k*PW +: PW];
         end
      end
   end

   // Running min/max including this cycle's candidate; index 0 seeds both.
   always_comb begin
      min_n     = min_q;
      max_n     = max_q;
      min_idx_n = min_idx_q;
      max_idx_n = max_idx_q;
      if (scan_q == '0) begin
         min_n     = cur_price;
         max_n     = cur_price;
         min_idx_n = '0;
         max_idx_n = '0;
      end else begin
         if (cur_price < min_q) begin
            min_n     = cur_price;
            min_idx_n = scan_q;
         end
         if (cur_price > max_q) begin
            max_n     = cur_price;
            max_idx_n = scan_q;
         end
      end
      spread_n = max_n - min_n;
   end

   always_comb begin
      state_d      = state_q;
      pidx_d       = pidx_q;
      bidx_d       = bidx_q;
      csum_d       = csum_q;
      tmo_d        = tmo_q;
      shadow_d     = shadow_q;
      scan_d       = scan_q;
      min_d        = min_q;
      max_d        = max_q;
      min_idx_d    = min_idx_q;
      max_idx_d    = max_idx_q;
      prices_d     = prices_q;
      buy_idx_d    = buy_idx_q;
      sell_idx_d   = sell_idx_q;
      spread_d     = spread_q;
      profitable_d = profitable_q;
      out_valid_d  = 1'b0;
      frame_err_d  = 1'b0;
      err_code_d   = err_code_q;

      case (state_q)
         S_IDLE: begin
            if (rx_valid && (rx_data == HEADER)) begin
               state_d = S_PRICE;
               pidx_d  = '0;
               bidx_d  = '0;
               csum_d  = '0;
               tmo_d   = '0;
            end
         end

         S_PRICE: begin
            if (rx_valid) begin
               // MSB-first within a price: byte j lands at slot PRICE_BYTES-1-j.
               for (int k = 0; k < N_EXCH; k++) begin
                  for (int j = 0; j < PRICE_BYTES; j++) begin
                     if ((pidx_q == IW'(k)) && (bidx_q == BW'(j))) begin
                        shadow_d[k*PW + (PRICE_BYTES-1-j)*8 +: 8] = rx_data;
                     end
                  end
               end
               csum_d = csum_q ^ rx_data;
               if (bidx_q == BW'(PRICE_BYTES-1)) begin
                  bidx_d = '0;
                  if (pidx_q == IW'(N_EXCH-1)) begin
                     state_d = S_CHECK;
                  end else begin
                     pidx_d = pidx_q + IW'(1);
                  end
               end else begin
                  bidx_d = bidx_q + BW'(1);
               end
            end
         end

         S_CHECK: begin
            if (rx_valid) begin
               if (rx_data == csum_q) begin
                  state_d = S_FOOT;
               end else begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd1;
               end
            end
         end

         S_FOOT: begin
            if (rx_valid) begin
               if (rx_data == FOOTER) begin
                  state_d = S_SCAN;
                  scan_d  = '0;
               end else begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
                  err_code_d  = 2'd2;
               end
            end
         end

         S_SCAN: begin
            min_d     = min_n;
            max_d     = max_n;
            min_idx_d = min_idx_n;
            max_idx_d = max_idx_n;
            if (scan_q == IW'(N_EXCH-1)) begin
               // Results are registered here so they appear together with out_valid in DONE.
               state_d      = S_DONE;
               prices_d     = shadow_q;
               buy_idx_d    = min_idx_n;
               sell_idx_d   = max_idx_n;
               spread_d     = spread_n;
               profitable_d = (spread_n > MIN_SPREAD);
               out_valid_d  = 1'b1;
            end else begin
               scan_d = scan_q + IW'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Inter-byte watchdog; an arriving byte always takes priority over expiry.
      if (in_frame) begin
         if (rx_valid) begin
            tmo_d = '0;
         end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pidx_q       <= '0;
         bidx_q       <= '0;
         csum_q       <= '0;
         tmo_q        <= '0;
         shadow_q     <= '0;
         scan_q       <= '0;
         min_q        <= '0;
         max_q        <= '0;
         min_idx_q    <= '0;
         max_idx_q    <= '0;
         prices_q     <= '0;
         buy_idx_q    <= '0;
         sell_idx_q   <= '0;
         spread_q     <= '0;
         profitable_q <= 1'b0;
         out_valid_q  <= 1'b0;
         frame_err_q  <= 1'b0;
         err_code_q   <= '0;
      end else begin
         state_q      <= state_d;
         pidx_q       <= pidx_d;
         bidx_q       <= bidx_d;
         csum_q       <= csum_d;
         tmo_q        <= tmo_d;
         shadow_q     <= shadow_d;
         scan_q       <= scan_d;
         min_q        <= min_d;
         max_q        <= max_d;
         min_idx_q    <= min_idx_d;
         max_idx_q    <= max_idx_d;
         prices_q     <= prices_d;
         buy_idx_q    <= buy_idx_d;
         sell_idx_q   <= sell_idx_d;
         spread_q     <= spread_d;
         profitable_q <= profitable_d;
         out_valid_q  <= out_valid_d;
         frame_err_q  <= frame_err_d;
         err_code_q   <= err_code_d;
      end
   end

   assign prices     = prices_q;
   assign buy_idx    = buy_idx_q;
   assign sell_idx   = sell_idx_q;
   assign spread     = spread_q;
   assign profitable = profitable_q;
   assign out_valid  = out_valid_q;
   assign frame_err  = frame_err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_arb_frame_parser.sv
// tb/tb_arb_frame_parser.sv - directed self-checking bench for arb_frame_parser
module tb_arb_frame_parser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  rx_data_a, rx_data_b;
   logic        rx_valid_a, rx_valid_b;

   logic [31:0] prices_a;
   logic        buy_idx_a, sell_idx_a;
   logic [15:0] spread_a;
   logic        profitable_a, out_valid_a, frame_err_a;
   logic [1:0]  err_code_a;

   logic [63:0] prices_b;
   logic [1:0]  buy_idx_b, sell_idx_b;
   logic [15:0] spread_b;
   logic        profitable_b, out_valid_b, frame_err_b;
   logic [1:0]  err_code_b;

   int n_asserts = 0;
   int n_fail    = 0;

   arb_frame_parser #(
      .N_EXCH(2), .PRICE_BYTES(2), .TIMEOUT_CYCLES(40), .MIN_SPREAD(16'd0)
   ) dut_a (
      .clk(clk), .rst(rst), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
      .prices(prices_a), .buy_idx(buy_idx_a), .sell_idx(sell_idx_a),
      .spread(spread_a), .profitable(profitable_a), .out_valid(out_valid_a),
      .frame_err(frame_err_a), .err_code(err_code_a)
   );

   arb_frame_parser #(
      .N_EXCH(4), .PRICE_BYTES(2), .TIMEOUT_CYCLES(40), .MIN_SPREAD(16'd250)
   ) dut_b (
      .clk(clk), .rst(rst), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
      .prices(prices_b), .buy_idx(buy_idx_b), .sell_idx(sell_idx_b),
      .spread(spread_b), .profitable(profitable_b), .out_valid(out_valid_b),
      .frame_err(frame_err_b), .err_code(err_code_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] b);
      rx_data_a  = b;
      rx_valid_a = 1'b1;
      step();
      rx_valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      rx_data_b  = b;
      rx_valid_b = 1'b1;
      step();
      rx_valid_b = 1'b0;
   endtask

   // Call right after the footer byte; out_valid must rise on the N_EXCH-th step (footer cycle + 3).
   task automatic wait_result_a(input string tag, input logic [31:0] p, input logic bi,
                                input logic si, input logic [15:0] sp, input logic pr);
      for (int i = 1; i <= 2; i++) begin
         step();
         check({tag, ".out_valid"}, out_valid_a, (i == 2));
      end
      check({tag, ".frame_err"}, frame_err_a, 1'b0);
      check({tag, ".prices"}, prices_a, p);
      check({tag, ".buy_idx"}, buy_idx_a, bi);
      check({tag, ".sell_idx"}, sell_idx_a, si);
      check({tag, ".spread"}, spread_a, sp);
      check({tag, ".profitable"}, profitable_a, pr);
      step();
      check({tag, ".out_valid_drop"}, out_valid_a, 1'b0);
   endtask

   task automatic wait_result_b(input string tag, input logic [63:0] p, input logic [1:0] bi,
                                input logic [1:0] si, input logic [15:0] sp, input logic pr);
      for (int i = 1; i <= 4; i++) begin
         step();
         check({tag, ".out_valid"}, out_valid_b, (i == 4));
      end
      check({tag, ".prices"}, prices_b, p);
      check({tag, ".buy_idx"}, buy_idx_b, bi);
      check({tag, ".sell_idx"}, sell_idx_b, si);
      check({tag, ".spread"}, spread_b, sp);
      check({tag, ".profitable"}, profitable_b, pr);
      step();
      check({tag, ".out_valid_drop"}, out_valid_b, 1'b0);
   endtask

   initial begin
      rst        = 1'b0;
      rx_data_a  = 8'h00;
      rx_data_b  = 8'h00;
      rx_valid_a = 1'b0;
      rx_valid_b = 1'b0;
      step();
      step();

      check("rst.prices_a", prices_a, 32'h0);
      check("rst.out_a", {buy_idx_a, sell_idx_a, spread_a, profitable_a, out_valid_a, frame_err_a, err_code_a}, 0);
      check("rst.prices_b", prices_b, 64'h0);
      check("rst.out_b", {buy_idx_b, sell_idx_b, spread_b, profitable_b, out_valid_b, frame_err_b, err_code_b}, 0);
      rst = 1'b1;
      step();

      // Basic frame: 0x10AE / 0x108B.
      send_a(8'hAA); send_a(8'h10); send_a(8'hAE); send_a(8'h10); send_a(8'h8B); send_a(8'h25);
      send_a(8'h55);
      wait_result_a("good1", 32'h108B_10AE, 1'b1, 1'b0, 16'd35, 1'b1);

      // Bad checksum.
      send_a(8'hAA); send_a(8'h10); send_a(8'hAE); send_a(8'h10); send_a(8'h8B);
      send_a(8'h24);
      check("csum.frame_err", frame_err_a, 1'b1);
      check("csum.err_code", err_code_a, 2'd1);
      check("csum.out_valid", out_valid_a, 1'b0);
      check("csum.prices", prices_a, 32'h108B_10AE);
      step();
      check("csum.frame_err_drop", frame_err_a, 1'b0);
      send_a(8'h55);
      for (int i = 0; i < 3; i++) begin
         step();
         check("csum.no_result", {out_valid_a, frame_err_a}, 2'b00);
      end

      // Leading garbage then bad footer.
      send_a(8'h00); send_a(8'h55); send_a(8'h13);
      send_a(8'hAA); send_a(8'h10); send_a(8'hAE); send_a(8'h10); send_a(8'h8B); send_a(8'h25);
      send_a(8'h56);
      check("foot.frame_err", frame_err_a, 1'b1);
      check("foot.err_code", err_code_a, 2'd2);
      check("foot.prices", prices_a, 32'h108B_10AE);

      // Equal prices: both indices 0, zero spread, not profitable.
      send_a(8'hAA); send_a(8'h12); send_a(8'h34); send_a(8'h12); send_a(8'h34); send_a(8'h00);
      send_a(8'h55);
      wait_result_a("equal", 32'h1234_1234, 1'b0, 1'b0, 16'd0, 1'b0);
      check("equal.err_code_held", err_code_a, 2'd2);

      // HEADER/FOOTER values inside price data are plain data.
      send_a(8'hAA); send_a(8'hAA); send_a(8'h55); send_a(8'h01); send_a(8'h00); send_a(8'hFE);
      send_a(8'h55);
      wait_result_a("hdrdata", 32'h0100_AA55, 1'b1, 1'b0, 16'hA955, 1'b1);

      // Four exchanges 100,300,50,300: tie on max goes to index 1; spread 250 is not > 250.
      send_b(8'hAA); send_b(8'h00); send_b(8'h64); send_b(8'h01); send_b(8'h2C);
      send_b(8'h00); send_b(8'h32); send_b(8'h01); send_b(8'h2C); send_b(8'h56);
      send_b(8'h55);
      wait_result_b("n4a", 64'h012C_0032_012C_0064, 2'd2, 2'd1, 16'd250, 1'b0);

      // Four exchanges 50,301,64,80: spread 251 crosses the threshold.
      send_b(8'hAA); send_b(8'h00); send_b(8'h32); send_b(8'h01); send_b(8'h2D);
      send_b(8'h00); send_b(8'h40); send_b(8'h00); send_b(8'h50); send_b(8'h0E);
      send_b(8'h55);
      wait_result_b("n4b", 64'h0050_0040_012D_0032, 2'd0, 2'd1, 16'd251, 1'b1);

      // Timeout: counter reaches 40 after 40 idle edges, error one edge later.
      send_a(8'hAA); send_a(8'h10); send_a(8'hAE);
      for (int i = 1; i <= 41; i++) begin
         step();
         check("tmo.frame_err", frame_err_a, (i == 41));
      end
      check("tmo.err_code", err_code_a, 2'd3);
      check("tmo.prices", prices_a, 32'h0100_AA55);
      send_a(8'hAA); send_a(8'h00); send_a(8'h01); send_a(8'h00); send_a(8'h02); send_a(8'h03);
      send_a(8'h55);
      wait_result_a("after_tmo", 32'h0002_0001, 1'b0, 1'b1, 16'd1, 1'b1);

      // Reset mid-frame clears outputs at once; the tail of the partial frame is ignored.
      send_a(8'hAA); send_a(8'h10); send_a(8'hAE); send_a(8'h10);
      rst = 1'b0;
      #1;
      check("mrst.prices_a", prices_a, 32'h0);
      check("mrst.out_a", {buy_idx_a, sell_idx_a, spread_a, profitable_a, out_valid_a, frame_err_a, err_code_a}, 0);
      check("mrst.prices_b", prices_b, 64'h0);
      step();
      rst = 1'b1;
      send_a(8'h8B); send_a(8'h25); send_a(8'h55);
      for (int i = 0; i < 4; i++) begin
         step();
         check("mrst.no_result", {out_valid_a, frame_err_a}, 2'b00);
      end
      send_a(8'hAA); send_a(8'h10); send_a(8'hAE); send_a(8'h10); send_a(8'h8B); send_a(8'h25);
      send_a(8'h55);
      wait_result_a("post_rst", 32'h108B_10AE, 1'b1, 1'b0, 16'd35, 1'b1);
      check("post_rst.err_code", err_code_a, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
